// File: rtl/debug_trace_serializer_if.sv
// ---------------------------------------------------------------------------
// debug_trace_serializer_if
// Bundles the debug capture inputs and the pmod/status outputs of
// debug_trace_serializer. The master side drives the debug bus (the core or a
// testbench); the slave side is the serializer itself.
// ---------------------------------------------------------------------------
interface debug_trace_serializer_if #(
  parameter int INFO_W = 4,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              en;          // capture enable, also gates the timestamp
  logic [INFO_W-1:0] debug_info;  // {debug_stall, debug_state}
  logic [3:0]        pmod_out;    // {overflow, ser_frm, ser_dat, ser_clk}
  logic [LVL_W-1:0]  fifo_level;  // current FIFO occupancy
  logic              busy;        // serializer active or records queued

  modport master (
    output en, debug_info,
    input  pmod_out, fifo_level, busy
  );

  modport slave (
    input  en, debug_info,
    output pmod_out, fifo_level, busy
  );
endinterface

// File: rtl/debug_trace_serializer.sv
// ---------------------------------------------------------------------------
// debug_trace_serializer
// Watches the core's debug bus, timestamps every change with a free-running
// cycle counter, queues {timestamp, debug_info} records in a FIFO and shifts
// them out MSB first on a slow framed serial link (ser_clk/ser_dat/ser_frm)
// that a logic analyzer can follow.
//
// Optional build macro DEBUG_TRACE_PARITY_EN: appends one even-parity bit
// after the record LSB, making each frame REC_W+1 bits long.
// ---------------------------------------------------------------------------
module debug_trace_serializer #(
  parameter int INFO_W = 4,   // debug_info width (stall + state)
  parameter int TS_W   = 12,  // timestamp width, wraps modulo 2^TS_W
  parameter int DEPTH  = 16,  // FIFO entries, power of two, >= 2
  parameter int DIV    = 4    // ser_clk half-period in clk cycles, >= 1
) (
  input logic                     clk,
  input logic                     rst,
  debug_trace_serializer_if.slave bus
);

  localparam int REC_W = TS_W + INFO_W;
`ifdef DEBUG_TRACE_PARITY_EN
  localparam int FRAME_W = REC_W + 1;
`else
  localparam int FRAME_W = REC_W;
`endif
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = $clog2(2 * DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  // -------------------------------------------------------------------------
  // Timestamp and change detection
  // -------------------------------------------------------------------------
  logic [TS_W-1:0]   r_ts;
  logic [INFO_W-1:0] r_prev;
  logic              w_event;
  logic [REC_W-1:0]  w_record;

  // Cycle counter and last-seen debug value, both frozen while capture is off.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts   <= '0;
      r_prev <= '0;
    end else if (bus.en) begin
      r_ts   <= r_ts + TS_W'(1);
      r_prev <= bus.debug_info;
    end
  end

  // prev resets to zero, so a non-zero value on the first enabled cycle is
  // an event; the record carries the timestamp before this cycle's increment.
  assign w_event  = bus.en && (bus.debug_info != r_prev);
  assign w_record = {r_ts, bus.debug_info};

  // -------------------------------------------------------------------------
  // Record FIFO
  // -------------------------------------------------------------------------
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             r_overflow;
  logic [REC_W-1:0] w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LVL_W'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_push = w_event && (!w_full || w_pop);
  assign w_drop = w_event && w_full && !w_pop;

  // Record storage write port.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, and a reset array would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_record;
    end
  end

  // Read/write pointers and the sticky overflow flag (cleared only by rst).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Serializer FSM
  // -------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] w_shift_nxt;
  logic [FRAME_W-1:0] w_frame_load;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   w_div_cnt_nxt;
  logic               r_phase;       // 0 = ser_clk low half, 1 = high half
  logic               w_phase_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic               r_ser_clk;
  logic               r_ser_dat;
  logic               r_ser_frm;

`ifdef DEBUG_TRACE_PARITY_EN
  // Even parity: the appended bit makes the frame's count of ones even.
  assign w_frame_load = {w_head, ^w_head};
`else
  assign w_frame_load = w_head;
`endif

  // Next-state logic: bit timing, frame sequencing and FIFO pop request.
  // NOTE: every signal driven here gets a default first, so no branch can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_div_cnt_nxt = r_div_cnt;
    w_phase_nxt   = r_phase;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pop         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_state_nxt   = S_SHIFT;
          w_shift_nxt   = w_frame_load;
          w_bit_cnt_nxt = BIT_W'(FRAME_W);
          w_div_cnt_nxt = '0;
          w_phase_nxt   = 1'b0;
        end
      end

      S_SHIFT: begin
        if (r_div_cnt == DIV_W'(DIV - 1)) begin
          w_div_cnt_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else if (r_bit_cnt == BIT_W'(1)) begin
            // Last bit's high phase is complete.
            w_phase_nxt   = 1'b0;
            w_gap_cnt_nxt = '0;
            w_state_nxt   = S_GAP;
          end else begin
            // Next bit appears together with the falling edge of ser_clk.
            w_phase_nxt   = 1'b0;
            w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt - BIT_W'(1);
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_W'(2 * DIV - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Serial pins are registered from next-state values so they line up with
  // the state they describe and never see debug_info combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ser_frm <= 1'b0;
      r_ser_clk <= 1'b0;
      r_ser_dat <= 1'b0;
    end else begin
      r_ser_frm <= (w_state_nxt == S_SHIFT);
      r_ser_clk <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
      r_ser_dat <= (w_state_nxt == S_SHIFT) && w_shift_nxt[FRAME_W-1];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.pmod_out   = {r_overflow, r_ser_frm, r_ser_dat, r_ser_clk};
  assign bus.fifo_level = w_level;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_debug_trace_serializer.sv
// ---------------------------------------------------------------------------
// tb_debug_trace_serializer
// Directed bench for debug_trace_serializer. A small behavioural model of the
// timestamp/change detector pushes expected records into a scoreboard; a
// frame monitor decodes pmod_out and compares each frame against it.
// Build with DEBUG_TRACE_PARITY_EN to exercise the parity frame format.
// ---------------------------------------------------------------------------
module tb_debug_trace_serializer;

  localparam int INFO_W = 4;
  localparam int TS_W   = 12;
  localparam int DEPTH  = 16;
  localparam int DIV    = 4;
  localparam int REC_W  = TS_W + INFO_W;
`ifdef DEBUG_TRACE_PARITY_EN
  localparam int          FRAME_W = REC_W + 1;
  localparam logic [31:0] EXP_S2  = 32'h0000_00B4;  // {16'h005A, parity 0}
`else
  localparam int          FRAME_W = REC_W;
  localparam logic [31:0] EXP_S2  = 32'h0000_005A;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_trace_serializer_if #(.INFO_W(INFO_W), .DEPTH(DEPTH)) bus ();

  debug_trace_serializer #(
    .INFO_W(INFO_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .DIV   (DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of timestamp + change detection, and the scoreboard.
  logic [REC_W-1:0]  sb[$];
  logic [TS_W-1:0]   m_ts;
  logic [INFO_W-1:0] m_prev;
  logic              cur_en;
  logic [INFO_W-1:0] cur_info;

  task automatic model_reset();
    m_ts   = '0;
    m_prev = '0;
    sb.delete();
  endtask

  // Drive one clock's worth of inputs at the falling edge; keep=0 marks an
  // event the bench knows the FIFO must drop.
  task automatic step(input logic e, input logic [INFO_W-1:0] d, input bit keep);
    @(negedge clk);
    bus.en         = e;
    bus.debug_info = d;
    cur_en         = e;
    cur_info       = d;
    if (e) begin
      if (d != m_prev && keep) sb.push_back({m_ts, d});
      m_prev = d;
      m_ts   = m_ts + 1'b1;
    end
  endtask

  // Frame monitor: samples pmod_out on falling clk edges.
  logic        mon_frm_q = 1'b0;
  logic        mon_clk_q = 1'b0;
  logic [31:0] mon_shift = '0;
  logic [31:0] last_frame = '0;
  int          mon_bits = 0;
  int          mon_hi = 0;
  int          mon_lo_run = 0;
  bit          mon_gap_valid = 1'b0;
  int          frames = 0;
  int          gap_bad = 0;

  always @(negedge clk) begin
    logic             frm;
    logic             sck;
    logic             dat;
    logic [REC_W-1:0] exp_rec;
    logic [31:0]      exp_frame;
    if (rst) begin
      mon_frm_q     = 1'b0;
      mon_clk_q     = 1'b0;
      mon_bits      = 0;
      mon_hi        = 0;
      mon_gap_valid = 1'b0;
    end else begin
      frm = bus.pmod_out[2];
      dat = bus.pmod_out[1];
      sck = bus.pmod_out[0];
      if (frm) begin
        if (!mon_frm_q) begin
          if (mon_gap_valid && mon_lo_run < 2 * (2 * DIV + 1))
            check("frame_spacing", mon_lo_run, 2 * DIV + 1);
          mon_bits  = 0;
          mon_hi    = 0;
          mon_shift = '0;
        end
        mon_hi++;
        if (sck && !mon_clk_q) begin
          mon_shift = {mon_shift[30:0], dat};
          mon_bits++;
        end
      end else begin
        if (mon_frm_q) begin
          check("frame_len", mon_hi, 2 * DIV * FRAME_W);
          check("frame_bits", mon_bits, FRAME_W);
          check("sb_has_entry", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            exp_rec = sb.pop_front();
`ifdef DEBUG_TRACE_PARITY_EN
            exp_frame = 32'({exp_rec, ^exp_rec});
`else
            exp_frame = 32'(exp_rec);
`endif
            check("frame_data", mon_shift, exp_frame);
          end
          last_frame    = mon_shift;
          frames++;
          mon_lo_run    = 0;
          mon_gap_valid = 1'b1;
        end
        mon_lo_run++;
        if (sck || dat) gap_bad++;
      end
      mon_frm_q = frm;
      mon_clk_q = sck;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.debug_info = '0;
    cur_en         = 1'b0;
    cur_info       = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pmod", bus.pmod_out, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
  endtask

  // Hold inputs steady until every expected frame is out and the DUT is idle.
  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      step(cur_en, cur_info, 1'b1);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int idle_bad;
    int n;
    bus.en         = 1'b0;
    bus.debug_info = '0;
    cur_en         = 1'b0;
    cur_info       = '0;
    model_reset();

    // 1. Idle: debug_info constant zero for 500 enabled cycles.
    do_reset();
    idle_bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, '0, 1'b1);
      if (bus.pmod_out != 0 || bus.fifo_level != 0 || bus.busy) idle_bad++;
    end
    check("idle_quiet", idle_bad, 0);

    // 2. Single event: debug_info=A at ts=5 -> record 16'h005A.
    do_reset();
    f0 = frames;
    repeat (5) step(1'b1, '0, 1'b1);
    step(1'b1, 4'hA, 1'b1);
    step(1'b1, 4'hA, 1'b1);
    check("s2_level_next_cycle", bus.fifo_level, 1);
    check("s2_busy", bus.busy, 1);
    drain(600);
    check("s2_frame_count", frames - f0, 1);
    check("s2_record", last_frame, EXP_S2);
    check("s2_pmod_idle", bus.pmod_out, 0);

    // 3. Overflow: 20 consecutive changes, 17 accepted, 3 dropped.
    do_reset();
    f0 = frames;
    for (int i = 0; i < 20; i++) step(1'b1, INFO_W'(i + 1), i < 17);
    step(1'b1, cur_info, 1'b1);
    check("s3_level_full", bus.fifo_level, DEPTH);
    check("s3_overflow_set", bus.pmod_out[3], 1);
    drain(3000);
    check("s3_frame_count", frames - f0, 17);
    check("s3_overflow_sticky", bus.pmod_out[3], 1);
    check("s3_level_empty", bus.fifo_level, 0);

    // 4. Enable gating: freeze at ts=100, toggle, resume.
    do_reset();
    f0 = frames;
    while (m_ts != TS_W'(99)) step(1'b1, '0, 1'b1);
    step(1'b1, 4'h3, 1'b1);                    // record {99, 3}
    for (int i = 0; i < 10; i++) step(1'b0, (i % 2 == 0) ? 4'h5 : 4'h3, 1'b1);
    step(1'b0, 4'h3, 1'b1);
    check("s4_no_push_while_off", bus.fifo_level, 0);
    step(1'b1, 4'h3, 1'b1);                    // same as value at ts=99: no event
    step(1'b1, 4'h6, 1'b1);                    // record {101, 6}
    repeat (3) step(1'b0, 4'h9, 1'b1);
    step(1'b1, 4'h9, 1'b1);                    // differs from 6: event on resume
    drain(1200);
    check("s4_frame_count", frames - f0, 3);

    // 5. Reset mid-frame: overflow set, then rst during bit 7.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, INFO_W'(i + 1), i < 17);
    step(1'b1, cur_info, 1'b1);
    check("s5_overflow_before", bus.pmod_out[3], 1);
    n = 0;
    while (!(mon_frm_q && mon_bits == 7) && n < 2000) begin
      step(1'b1, cur_info, 1'b1);
      n++;
    end
    check("s5_reached_bit7", n < 2000, 1);
    #3 rst = 1'b1;
    #1;
    check("s5_pmod_cleared", bus.pmod_out, 0);
    check("s5_level_cleared", bus.fifo_level, 0);
    check("s5_busy_cleared", bus.busy, 0);
    model_reset();
    bus.en         = 1'b0;
    bus.debug_info = '0;
    cur_en         = 1'b0;
    cur_info       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0  = frames;
    repeat (3) step(1'b1, '0, 1'b1);
    step(1'b1, 4'h7, 1'b1);                    // record {3, 7}
    drain(600);
    check("s5_frame_after_reset", frames - f0, 1);
    check("s5_overflow_stays_clear", bus.pmod_out[3], 0);

    check("gap_pins_quiet", gap_bad, 0);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_trace_serializer.md
Name: debug_trace_serializer

Overview:
- Sits downstream of RV32core's debug outputs (debug_stall, debug_state) and drives the 4-pin pmod header.
- Detects changes on the debug bus and timestamps each change with a free-running cycle counter.
- Buffers the timestamped records in a FIFO and shifts them out serially, so a slow logic analyzer can reconstruct pipeline stall/state history without losing events.

Parameters:
- INFO_W, 4, width of debug_info (stall + 3-bit state).
- TS_W, 12, timestamp counter width; wraps modulo 2^TS_W.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DIV, 4, ser_clk half-period in clk cycles; at least 1.

Ports:
- clk  input  1  CPU clock (clk_cpu domain).
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; also gates the timestamp counter.
- debug_info  input  INFO_W  {debug_stall, debug_state} from the core.
- pmod_out  output  4  {overflow, ser_frm, ser_dat, ser_clk}.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  high when the serializer is outside IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async, active-high):
  - pmod_out=0, fifo_level=0, busy=0.
  - Timestamp ts=0, prev=0, FSM=IDLE, shift register=0, overflow=0.
- Timestamp: ts increments by 1 every clk while en=1, wraps to 0 after all-ones, and holds while en=0.
- Change detection:
  - prev <= debug_info every cycle with en=1.
  - An event occurs when en=1 and debug_info != prev.
  - If debug_info is non-zero on the first enabled cycle after reset, that cycle produces an event.
- Record format: REC_W = TS_W + INFO_W, laid out as {ts_at_event, debug_info}. ts is sampled before its increment in the same cycle.
- FIFO push:
  - An event pushes one record; fifo_level reflects it the following cycle.
  - If the FIFO is full and no pop happens that cycle, the record is dropped and overflow sets sticky. Only rst clears overflow.
  - A push and a pop in the same cycle both occur, leaving the level unchanged; a push while full succeeds if a pop happens in the same cycle.
- Serializer FSM:
  - IDLE: ser_frm=0, ser_clk=0. If fifo_level != 0, pop the head into the shift register, set bit count = REC_W, go to SHIFT.
  - SHIFT:
    - ser_frm=1; bits go out MSB first.
    - Each bit lasts 2*DIV cycles: ser_clk low for DIV cycles, then high for DIV cycles.
    - ser_dat changes only at the start of the low phase; the receiver samples on the ser_clk rising edge.
    - After the last bit's high phase, go to GAP.
  - GAP: ser_frm=0, ser_clk=0, ser_dat=0 for 2*DIV cycles, then IDLE.
  - Back-to-back frame period is 2*DIV*(REC_W+1)+1 cycles.
- en=0 does not stop the serializer; queued records still drain.
- Reset mid-frame: outputs go to 0 immediately; the partial frame is abandoned and the FIFO is emptied.
- All pmod_out bits are registered; there is no combinational path from debug_info to pmod_out.

Optional Feature:
- DEBUG_TRACE_PARITY_EN defined: one even-parity bit over the REC_W record bits is appended after the LSB. The frame becomes REC_W+1 bits with identical clocking.
- Not defined: the frame is exactly REC_W bits and there is no parity logic.

Test Plan:
All scenarios use the defaults INFO_W=4, TS_W=12, DEPTH=16, DIV=4, REC_W=16.

1. Idle:
   - Stimulus: release reset, en=1, debug_info held at 0 for 500 cycles.
   - Required: pmod_out=0, fifo_level=0, busy=0 throughout.
2. Single event:
   - Stimulus: en=1 from reset release (ts=0); set debug_info=4'hA on the cycle ts=5.
   - Required:
     - Record 16'h005A.
     - ser_frm high for 128 cycles.
     - The 16 rising edges of ser_clk sample 0000_0000_0101_1010.
     - Then a 8-cycle gap.
3. Overflow:
   - Stimulus: debug_info changes on 20 consecutive cycles starting at the first enabled cycle.
   - Required:
     - 17 records accepted (1 popped immediately, 16 queued) and 3 dropped.
     - overflow=1, holding until rst.
     - Exactly 17 frames are emitted, with timestamps ascending.
4. Enable gating:
   - Stimulus: en=0 at ts=100; toggle debug_info 10 times; restore en=1.
   - Required:
     - No new records while en=0.
     - ts resumes from 100.
     - The first enabled cycle emits an event only if debug_info differs from the value captured at ts=99.
5. Reset mid-frame:
   - Stimulus: assert rst during bit 7 of a frame.
   - Required:
     - pmod_out=0 in the same cycle.
     - fifo_level=0 and overflow=0.
     - After release, the next event produces a complete, correct frame.
6. Parity build:
   - Stimulus: build with DEBUG_TRACE_PARITY_EN and repeat scenario 2.
   - Required: 17-bit frame ending in parity bit 0 (four ones); ser_frm high for 136 cycles.
